ula_exec: RTL and testbench

//  Multi-cycle ALU (ULA) that consumes the 4-bit ALUControl code produced by ula_ctrl and executes it.

---
 rtl/ula_pkg.sv | 61 ++++++
 rtl/ula_shift_step.sv | 30 +++
 rtl/ula_exec.sv | 179 +++++++++++++++++
 tb/tb_ula_exec.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ula_pkg : ALUControl codes, FSM state encoding and opcode decoders    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ula_pkg;

  localparam logic [3:0] ULA_AND     = 4'b0000;
  localparam logic [3:0] ULA_OR      = 4'b0001;
  localparam logic [3:0] ULA_ADD     = 4'b0010;
  localparam logic [3:0] ULA_SLLV    = 4'b0011;
  localparam logic [3:0] ULA_SRLV    = 4'b0100;
  localparam logic [3:0] ULA_SRAV    = 4'b0101;
  localparam logic [3:0] ULA_SUB     = 4'b0110;
  localparam logic [3:0] ULA_SLT     = 4'b0111;
  localparam logic [3:0] ULA_BNE     = 4'b1000;
  localparam logic [3:0] ULA_SLL     = 4'b1001;
  localparam logic [3:0] ULA_SRL     = 4'b1010;
  localparam logic [3:0] ULA_XOR     = 4'b1011;
  localparam logic [3:0] ULA_NOR     = 4'b1100;
  localparam logic [3:0] ULA_SRA     = 4'b1101;
  localparam logic [3:0] ULA_ILLEGAL = 4'b1110;
  localparam logic [3:0] ULA_SLTU    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ula_state_t;

  function automatic logic is_shift(input logic [3:0] code);
    case (code)
      ULA_SLLV, ULA_SRLV, ULA_SRAV, ULA_SLL, ULA_SRL, ULA_SRA: is_shift = 1'b1;
      default:                                                 is_shift = 1'b0;
    endcase
  endfunction

  // Variable shifts take their count from a[4:0] instead of shamt.
  function automatic logic uses_reg_count(input logic [3:0] code);
    case (code)
      ULA_SLLV, ULA_SRLV, ULA_SRAV: uses_reg_count = 1'b1;
      default:                      uses_reg_count = 1'b0;
    endcase
  endfunction

  function automatic logic shift_right(input logic [3:0] code);
    case (code)
      ULA_SRLV, ULA_SRAV, ULA_SRL, ULA_SRA: shift_right = 1'b1;
      default:                              shift_right = 1'b0;
    endcase
  endfunction

  function automatic logic shift_arith(input logic [3:0] code);
    case (code)
      ULA_SRAV, ULA_SRA: shift_arith = 1'b1;
      default:           shift_arith = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ula_shift_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ula_shift_step : combinational shift of WIDTH bits by 0..SHIFT_STEP   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ula_shift_step #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1,
  parameter int AMT_W      = $clog2(SHIFT_STEP + 1)
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir_right,
  input  logic             arith,
  output logic [WIDTH-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    if (!dir_right) begin
      data_out = data_in << amt;
    end else if (arith) begin
      data_out = WIDTH'($signed(data_in) >>> amt);
    end else begin
      data_out = data_in >> amt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ula_exec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ula_exec : multi-cycle ALU with valid/ready handshake, iterative shift|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ula_exec
  import ula_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int         AMT_W    = $clog2(SHIFT_STEP + 1);
  localparam logic [4:0] STEP_CNT = 5'(SHIFT_STEP);

  ula_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             dir_right_q, dir_right_d;
  logic             arith_q, arith_d;

  logic [WIDTH-1:0] sum, diff;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] op_result;
  logic             op_zero, op_ovf, op_illegal;
  logic [4:0]       op_cnt;
  logic             op_is_shift;
  logic [AMT_W-1:0] step_amt;
  logic [WIDTH-1:0] step_out;

  // Single-cycle operation unit, evaluated on the live inputs at accept time.
  always_comb begin
    sum         = a + b;
    diff        = a - b;
    add_ovf     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sub_ovf     = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    op_is_shift = is_shift(alu_control);
    op_cnt      = uses_reg_count(alu_control) ? a[4:0] : shamt;
    op_result   = '0;
    op_ovf      = 1'b0;
    op_illegal  = 1'b0;
    case (alu_control)
      ULA_AND:     op_result = a & b;
      ULA_OR:      op_result = a | b;
      ULA_ADD:     begin op_result = sum;  op_ovf = add_ovf; end
      ULA_SUB:     begin op_result = diff; op_ovf = sub_ovf; end
      ULA_BNE:     begin op_result = diff; op_ovf = sub_ovf; end
      ULA_SLT:     op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ULA_SLTU:    op_result = {{(WIDTH-1){1'b0}}, (a < b)};
      ULA_XOR:     op_result = a ^ b;
      ULA_NOR:     op_result = ~(a | b);
      ULA_ILLEGAL: op_illegal = 1'b1;
      default:     op_result = b;  // shift by zero passes b through
    endcase
    if (alu_control == ULA_BNE) begin
      op_zero = (a != b);
    end else if (op_illegal) begin
      op_zero = 1'b1;
    end else begin
      op_zero = (op_result == '0);
    end
  end

  always_comb begin
    step_amt = (cnt_q > STEP_CNT) ? AMT_W'(STEP_CNT) : AMT_W'(cnt_q);
  end

  ula_shift_step #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP),
    .AMT_W      (AMT_W)
  ) u_shift_step (
    .data_in   (shift_q),
    .amt       (step_amt),
    .dir_right (dir_right_q),
    .arith     (arith_q),
    .data_out  (step_out)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    dir_right_d = dir_right_q;
    arith_d     = arith_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (op_is_shift && (op_cnt != 5'd0)) begin
            state_d     = ST_SHIFT;
            shift_d     = b;
            cnt_d       = op_cnt;
            dir_right_d = shift_right(alu_control);
            arith_d     = shift_arith(alu_control);
          end else begin
            state_d    = ST_DONE;
            result_d   = op_result;
            zero_d     = op_zero;
            overflow_d = op_ovf;
            illegal_d  = op_illegal;
          end
        end
      end
      ST_SHIFT: begin
        shift_d = step_out;
        cnt_d   = cnt_q - 5'(step_amt);
        if (cnt_d == 5'd0) begin
          state_d    = ST_DONE;
          result_d   = step_out;
          zero_d     = (step_out == '0);
          overflow_d = 1'b0;
          illegal_d  = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      arith_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      dir_right_q <= dir_right_d;
      arith_q     <= arith_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_ula_exec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ula_exec : directed vectors, corner sequences and random ops       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ula_exec;
  import ula_pkg::*;

  localparam int WIDTH      = 32;
  localparam int SHIFT_STEP = 1;
  localparam int NV         = 14;
  localparam int NRAND      = 200;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready;
  logic        zero, overflow, illegal;
  logic [3:0]  alu_control;
  logic [31:0] a, b, result;
  logic [4:0]  shamt;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ula_exec #(.WIDTH(WIDTH), .SHIFT_STEP(SHIFT_STEP)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain arithmetic on the operation's definition.
  function automatic void model(input logic [3:0] code, input logic [31:0] av, input logic [31:0] bv,
                                input logic [4:0] sv, output logic [31:0] r, output logic z,
                                output logic o, output logic il, output int lat);
    longint sa, sb, wide;
    int n;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    r = 32'd0; o = 1'b0; il = 1'b0; n = 0; wide = 0;
    case (code)
      ULA_AND:  r = av & bv;
      ULA_OR:   r = av | bv;
      ULA_XOR:  r = av ^ bv;
      ULA_NOR:  r = ~(av | bv);
      ULA_ADD:  wide = sa + sb;
      ULA_SUB, ULA_BNE: wide = sa - sb;
      ULA_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      ULA_SLTU: r = (av < bv) ? 32'd1 : 32'd0;
      ULA_SLLV: begin n = int'(av[4:0]); r = bv << n; end
      ULA_SRLV: begin n = int'(av[4:0]); r = bv >> n; end
      ULA_SRAV: begin n = int'(av[4:0]); r = 32'($signed(bv) >>> n); end
      ULA_SLL:  begin n = int'(sv); r = bv << n; end
      ULA_SRL:  begin n = int'(sv); r = bv >> n; end
      ULA_SRA:  begin n = int'(sv); r = 32'($signed(bv) >>> n); end
      default:  il = 1'b1;
    endcase
    if (code == ULA_ADD || code == ULA_SUB || code == ULA_BNE) begin
      r = wide[31:0];
      o = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
    end
    if (code == ULA_BNE) z = (av != bv);
    else if (il)         z = 1'b1;
    else                 z = (r == 32'd0);
    lat = 1 + (n + SHIFT_STEP - 1) / SHIFT_STEP;
  endfunction

  // Issue one op, scramble inputs while busy, then complete the output handshake.
  task automatic do_op(input logic [3:0] code, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] sv, output logic [31:0] r, output logic z,
                       output logic o, output logic il, output int lat, output logic busy_ready);
    @(negedge clk);
    alu_control = code; a = av; b = bv; shamt = sv; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    lat = 1;
    busy_ready = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready = 1'b1;
      alu_control = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    r = result; z = zero; o = overflow; il = illegal;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_handshake_in_ready", 32'(in_ready), 32'd1);
    check("post_handshake_out_valid", 32'(out_valid), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'h0000_0000;
      1: pick = 32'h8000_0000;
      2: pick = 32'h7FFF_FFFF;
      3: pick = 32'hFFFF_FFFF;
      4: pick = 32'(int'($urandom_range(0, 40)));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er, r0;
    logic        z, o, il, ez, eo, eil, br, stable, busy_seen, ov_seen;
    int          lat, elat;

    vecs[0]  = '{ULA_ADD,     32'd5,          32'd7,          5'd0,  32'd12,         1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{ULA_SUB,     32'h8000_0000,  32'd1,          5'd0,  32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{ULA_BNE,     32'd9,          32'd9,          5'd0,  32'd0,          1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{ULA_SRA,     32'd0,          32'h8000_0000,  5'd4,  32'hF800_0000,  1'b0, 1'b0, 1'b0, 5};
    vecs[4]  = '{ULA_SLLV,    32'd0,          32'h0000_1234,  5'd7,  32'h0000_1234,  1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{ULA_SRLV,    32'd31,         32'hFFFF_FFFF,  5'd0,  32'd1,          1'b0, 1'b0, 1'b0, 32};
    vecs[6]  = '{ULA_ILLEGAL, 32'd3,          32'd4,          5'd0,  32'd0,          1'b1, 1'b0, 1'b1, 1};
    vecs[7]  = '{ULA_SLT,     32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1,          1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{ULA_SLTU,    32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1, 1'b0, 1'b0, 1};
    vecs[9]  = '{ULA_NOR,     32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{ULA_BNE,     32'd3,          32'd9,          5'd0,  32'hFFFF_FFFA,  1'b1, 1'b0, 1'b0, 1};
    vecs[11] = '{ULA_ADD,     32'h7FFF_FFFF,  32'd1,          5'd0,  32'h8000_0000,  1'b0, 1'b1, 1'b0, 1};
    vecs[12] = '{ULA_SRAV,    32'h0000_0020,  32'h8000_0000,  5'd9,  32'h8000_0000,  1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{ULA_SLL,     32'd0,          32'd1,          5'd31, 32'h8000_0000,  1'b0, 1'b0, 1'b0, 32};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 4'd0; a = 32'd0; b = 32'd0; shamt = 5'd0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", {29'd0, zero, overflow, illegal}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].shamt, r, z, o, il, lat, br);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("vec%0d_overflow", i), 32'(o), 32'(vecs[i].o));
      check($sformatf("vec%0d_illegal", i), 32'(il), 32'(vecs[i].il));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_in_ready", i), 32'(br), 32'd0);
    end

    // Backpressure: DONE held for 10 cycles with out_ready low.
    @(negedge clk);
    alu_control = ULA_ADD; a = 32'h7FFF_FFFF; b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out_valid_lat1", 32'(out_valid), 32'd1);
    r0 = result;
    stable = 1'b1; busy_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      alu_control = 4'($urandom); a = $urandom; b = $urandom; in_valid = 1'($urandom);
      @(negedge clk);
      if (result !== r0 || zero !== 1'b0 || overflow !== 1'b1 || illegal !== 1'b0 || out_valid !== 1'b1)
        stable = 1'b0;
      if (in_ready) busy_seen = 1'b1;
    end
    check("bp_result", r0, 32'h8000_0000);
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_in_ready_low", 32'(busy_seen), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_result_kept", result, 32'h8000_0000);

    // Reset during the third shift cycle of a 31-bit shift.
    @(negedge clk);
    alu_control = ULA_SLL; b = 32'd1; shamt = 5'd31; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_flags", {29'd0, zero, overflow, illegal}, 32'd0);
    reset_n = 1'b1;
    ov_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1'b1;
    end
    check("rst_mid_no_out_valid", 32'(ov_seen), 32'd0);

    for (int i = 0; i < NRAND; i++) begin
      logic [3:0]  c;
      logic [31:0] ra, rb;
      logic [4:0]  rs;
      c  = 4'($urandom);
      ra = pick();
      rb = pick();
      rs = 5'($urandom);
      model(c, ra, rb, rs, er, ez, eo, eil, elat);
      do_op(c, ra, rb, rs, r, z, o, il, lat, br);
      check($sformatf("rand%0d_c%0h_result", i, c), r, er);
      check($sformatf("rand%0d_c%0h_flags", i, c), {29'd0, z, o, il}, {29'd0, ez, eo, eil});
      check($sformatf("rand%0d_c%0h_latency", i, c), 32'(lat), 32'(elat));
      check($sformatf("rand%0d_busy_in_ready", i), 32'(br), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
